// File: rtl/simd_tlut_matmul.sv
// rtl/simd_tlut_matmul.sv - temporal-LUT SIMD matrix-multiply cell (optional macro: SIMD_CELL_SAT_EN)
module simd_tlut_matmul #(
  parameter int DIM_ROW1     = 3,
  parameter int DIM_COL1     = 3,
  parameter int DIM_ROW2     = 3,
  parameter int DIM_COL2     = 3,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                enable,
  input  logic [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]       input_bin,
  input  logic [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]      weight_bin,
  output logic [DIM_ROW1*DIM_COL2-1:0][ACC_WIDTH-1:0]         accumulated_mult,
  output logic                                                done
);

  // Accumulators are wide enough for the exact product sum, so they never wrap.
  localparam int ACCW = INPUT_WIDTH + WEIGHT_WIDTH + $clog2(DIM_COL1);
  localparam int NOUT = DIM_ROW1 * DIM_COL2;
  localparam int EXTW = (ACCW > ACC_WIDTH) ? ACCW : ACC_WIDTH;
  // Last counter value of a pass: T-1 where T = 2^INPUT_WIDTH-1.
  localparam logic [INPUT_WIDTH-1:0] LAST = INPUT_WIDTH'((2 ** INPUT_WIDTH) - 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                                           state_q;
  logic [INPUT_WIDTH-1:0]                           counter_q;
  logic [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]    a_q;
  logic [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]   b_q;
  logic [NOUT-1:0][ACCW-1:0]                        acc_q;
  logic [NOUT-1:0][ACCW-1:0]                        acc_d;
  logic [NOUT-1:0][ACC_WIDTH-1:0]                   result_q;
  logic [NOUT-1:0][ACC_WIDTH-1:0]                   result_d;
  logic                                             done_q;
  logic [ACCW-1:0]                                  tree_sum;

  // Narrow an exact sum to the output width: wrap by default, clamp when saturation is built in.
  function automatic logic [ACC_WIDTH-1:0] reduce_out(input logic [ACCW-1:0] v);
    logic [EXTW-1:0] ext;
    ext = EXTW'(v);
`ifdef SIMD_CELL_SAT_EN
    if (ext > EXTW'({ACC_WIDTH{1'b1}})) begin
      return {ACC_WIDTH{1'b1}};
    end
`endif
    return ext[ACC_WIDTH-1:0];
  endfunction

  // Per-output sum of weights whose input pulse is still high at this time step.
  always_comb begin
    acc_d    = acc_q;
    result_d = '0;
    tree_sum = '0;
    for (int i = 0; i < DIM_ROW1; i++) begin
      for (int j = 0; j < DIM_COL2; j++) begin
        tree_sum = '0;
        for (int k = 0; k < DIM_COL1; k++) begin
          if (a_q[i*DIM_COL1+k] > counter_q) begin
            tree_sum = tree_sum + ACCW'(b_q[k*DIM_COL2+j]);
          end
        end
        acc_d[i*DIM_COL2+j]    = acc_q[i*DIM_COL2+j] + tree_sum;
        result_d[i*DIM_COL2+j] = reduce_out(acc_d[i*DIM_COL2+j]);
      end
    end
  end

  // Pass sequencer: latch operands, step the time counter, publish the result at the end of a pass.
  // The final time step always completes; enable on that edge chooses restart versus return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            a_q       <= input_bin;
            b_q       <= weight_bin;
            acc_q     <= '0;
            counter_q <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (counter_q == LAST) begin
            result_q  <= result_d;
            done_q    <= 1'b1;
            acc_q     <= '0;
            counter_q <= '0;
            if (enable) begin
              a_q     <= input_bin;
              b_q     <= weight_bin;
            end else begin
              state_q <= IDLE;
            end
          end else if (enable) begin
            acc_q     <= acc_d;
            counter_q <= counter_q + INPUT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign accumulated_mult = result_q;
  assign done             = done_q;

endmodule

// File: tb/tb_simd_tlut_matmul.sv
// tb/tb_simd_tlut_matmul.sv - directed self-checking bench for simd_tlut_matmul
module tb_simd_tlut_matmul;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [8:0][3:0]   input_bin = '0;
  logic [8:0][3:0]   weight_bin = '0;
  logic [8:0][7:0]   accumulated_mult;
  logic              done;

  int checks = 0;
  int failures = 0;

  int ref_c[9] = '{111, 90, 69, 66, 54, 42, 21, 18, 15};
`ifdef SIMD_CELL_SAT_EN
  int ovf_val = 255;
`else
  int ovf_val = 163;
`endif

  simd_tlut_matmul dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .input_bin        (input_bin),
    .weight_bin       (weight_bin),
    .accumulated_mult (accumulated_mult),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ref();
    for (int e = 0; e < 9; e++) begin
      input_bin[e]  = 4'(8 - e);
      weight_bin[e] = 4'(8 - e);
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    enable = 1'b0;
    set_ref();
    repeat (3) tick();
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'd0) begin
        failures++;
        $display("FAIL reset_c[%0d] got=%0d want=0", e, accumulated_mult[e]);
      end
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL idle_done_count got=%0d want=0", seen);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'd0) begin
        failures++;
        $display("FAIL idle_c[%0d] got=%0d want=0", e, accumulated_mult[e]);
      end
    end
  endtask

  task automatic test_reference();
    int lat;
    do_reset();
    set_ref();
    enable = 1'b1;
    tick();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = k;
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL ref_latency got=%0d want=15", lat);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'(ref_c[e])) begin
        failures++;
        $display("FAIL ref_c[%0d] got=%0d want=%0d", e, accumulated_mult[e], ref_c[e]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // continues straight from test_reference with enable still high
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = k;
      if (k == 1) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL b2b_done_pulse got=%b want=0", done);
        end
      end
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_period got=%0d want=15", lat);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'(ref_c[e])) begin
        failures++;
        $display("FAIL b2b_c[%0d] got=%0d want=%0d", e, accumulated_mult[e], ref_c[e]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_reset();
    input_bin  = {9{4'hF}};
    weight_bin = {9{4'hF}};
    enable = 1'b1;
    tick();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = k;
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL ovf_latency got=%0d want=15", lat);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'(ovf_val)) begin
        failures++;
        $display("FAIL ovf_c[%0d] got=%0d want=%0d", e, accumulated_mult[e], ovf_val);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    int early;
    do_reset();
    set_ref();
    enable = 1'b1;
    tick();
    early = 0;
    repeat (7) begin
      tick();
      if (done === 1'b1) early++;
    end
    enable = 1'b0;
    repeat (5) begin
      tick();
      if (done === 1'b1) early++;
    end
    enable = 1'b1;
    lat = 12;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = 12 + k;
      if (done === 1'b1) break;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL stall_early_done got=%0d want=0", early);
    end
    checks++;
    if (lat != 20 || done !== 1'b1) begin
      failures++;
      $display("FAIL stall_latency got=%0d want=20", lat);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'(ref_c[e])) begin
        failures++;
        $display("FAIL stall_c[%0d] got=%0d want=%0d", e, accumulated_mult[e], ref_c[e]);
      end
    end
  endtask

  task automatic test_operand_change();
    int lat;
    int want;
    do_reset();
    for (int e = 0; e < 9; e++) begin
      input_bin[e]  = (e % 4 == 0) ? 4'd1 : 4'd0;
      weight_bin[e] = (e % 4 == 0) ? 4'd1 : 4'd0;
    end
    enable = 1'b1;
    tick();
    repeat (3) tick();
    input_bin = {9{4'hF}};
    lat = 3;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = 3 + k;
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL opchg_latency got=%0d want=15", lat);
    end
    for (int e = 0; e < 9; e++) begin
      want = (e % 4 == 0) ? 1 : 0;
      checks++;
      if (accumulated_mult[e] !== 8'(want)) begin
        failures++;
        $display("FAIL opchg_c[%0d] got=%0d want=%0d", e, accumulated_mult[e], want);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    int lat;
    int seen;
    do_reset();
    set_ref();
    enable = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) break;
    end
    // second pass is now running; advance to counter 9
    repeat (9) tick();
    rst = 1'b1;
    #1;
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'd0) begin
        failures++;
        $display("FAIL midrst_c[%0d] got=%0d want=0", e, accumulated_mult[e]);
      end
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_done got=%b want=0", done);
    end
    enable = 1'b0;
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_idle_done got=%0d want=0", seen);
    end
    enable = 1'b1;
    tick();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lat = k;
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL midrst_latency got=%0d want=15", lat);
    end
    for (int e = 0; e < 9; e++) begin
      checks++;
      if (accumulated_mult[e] !== 8'(ref_c[e])) begin
        failures++;
        $display("FAIL midrst_c_after[%0d] got=%0d want=%0d", e, accumulated_mult[e], ref_c[e]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_operand_change();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simd_tlut_matmul.md
Name: simd_tlut_matmul

Overview:
- Temporal-LUT SIMD matrix-multiply cell: computes C = A x B for one unsigned input matrix A (DIM_ROW1 x DIM_COL1) and one weight matrix B (DIM_ROW2 x DIM_COL2).
- Each input element is treated as a temporal pulse: over 2^INPUT_WIDTH-1 cycles, weights are gated by "input > t" and summed through per-output adder trees into accumulators.
- Sits as a compute tile in the TLUT accelerator datapath; results are held until the next pass completes.

Parameters:
- DIM_ROW1, 3, rows of A.
- DIM_COL1, 3, columns of A; must equal DIM_ROW2.
- DIM_ROW2, 3, rows of B.
- DIM_COL2, 3, columns of B.
- INPUT_WIDTH, 4, unsigned bits per A element.
- WEIGHT_WIDTH, 4, unsigned bits per B element.
- ACC_WIDTH, 8, bits per output element.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  start / run enable.
- input_bin  input  [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]  A; element r*DIM_COL1+c = A[r][c].
- weight_bin  input  [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]  B; element r*DIM_COL2+c = B[r][c].
- accumulated_mult  output  [DIM_ROW1*DIM_COL2-1:0][ACC_WIDTH-1:0]  C; element i*DIM_COL2+j = C[i][j].
- done  output  1  one-cycle pulse when accumulated_mult is updated.

Behaviour:
Reset and states
- rst=1 (async): state IDLE; counter=0; accumulators=0; latched operands=0; accumulated_mult=0; done=0.
- States: IDLE and RUN. T = 2^INPUT_WIDTH-1 (15 by default).
- IDLE, edge with enable=1: latch input_bin and weight_bin, clear accumulators, counter=0, go to RUN.
- IDLE, enable=0: no change.

RUN, per edge with enable=1
- For every (i,j): acc[i][j] += sum over k of (A[i][k] > counter ? B[k][j] : 0), using the latched operands.
- Each sum is a combinational adder tree of DIM_COL1 gated weights; then counter++.

RUN, enable=0
- Stall: counter, accumulators and outputs hold.

End of pass
- On the accumulating edge where counter==T-1, accumulated_mult is loaded with the final sums, and done=1 for the following cycle.
- Same edge, enable=1: re-latch operands, clear accumulators, counter=0, remain in RUN (back-to-back passes, period T cycles).
- Same edge, enable=0: go to IDLE.

Latency and result
- If the start edge is E0, the result is visible after edge E0+T (15 cycles).
- Result = exact unsigned sum over k of A[i][k]*B[k][j].
- Internal accumulators are INPUT_WIDTH+WEIGHT_WIDTH+clog2(DIM_COL1) bits wide, so they never overflow.
- Default output reduction: keep the low ACC_WIDTH bits (modulo 2^ACC_WIDTH).

Boundaries
- A element = 0 contributes nothing; A element = 2^INPUT_WIDTH-1 contributes its weight on all T cycles.
- Input changes during RUN are ignored until the next latch.
- accumulated_mult holds its last value through IDLE and stalls.
- rst mid-pass aborts immediately to reset values.

Optional Feature:
- Macro: SIMD_CELL_SAT_EN.
- Defined: each output element saturates to 2^ACC_WIDTH-1 when the exact sum exceeds it.
- Undefined: output wraps modulo 2^ACC_WIDTH.
- Timing and all other behaviour are identical in both builds.

Test Plan:
1. Reset check: hold rst=1 for 3 cycles with enable=0 -> accumulated_mult all 0, done=0. Then hold 20 more cycles with enable=0 and rst released -> values unchanged.
2. Reference matrix: input_bin = weight_bin = concatenation {0,1,2,3,4,5,6,7,8}, so A = B = [[8,7,6],[5,4,3],[2,1,0]]. Release rst, assert enable -> 15 cycles after the start edge, C = [[111,90,69],[66,54,42],[21,18,15]], done pulses once. With enable held high, the same values reappear with a done pulse every 15 cycles.
3. Overflow: all A and B elements = 15, exact sum 675 -> default build gives 163 in every element; with SIMD_CELL_SAT_EN defined, gives 255.
4. Stall: drop enable for 5 cycles starting at counter 7 of a pass -> done arrives 20 cycles after start; result still equals the scenario 2 values.
5. Operand change mid-pass: A and B = identity at start, switch input_bin to all 15 at counter 3 -> C = identity matrix (1 on the diagonal, 0 elsewhere).
6. Reset mid-pass: assert rst at counter 9 -> immediately all outputs 0 and state IDLE. Re-enable -> correct result 15 cycles later.
